// File: rtl/sa_result_drain.sv
// sa_result_drain
//   Read-side companion to the output-stationary systolic array. On a start
//   pulse the whole y_axis x x_axis accumulator matrix is snapshotted into a
//   local bank, a one-cycle clr_req is sent back to the array so it can begin
//   the next tile, and the bank is streamed out one row per valid/ready beat.
//   Each element is reduced from WIDTH_MAC to WIDTH_OUT bits on the way out.
//
// Build option
//   SA_DRAIN_SAT_EN : when defined, the width reduction saturates (signed or
//                     unsigned depending on SIGNED); otherwise it truncates.
//
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   start        : pulse, array results are final and may be captured
//   mac_flat     : flattened array results, element [r][c] at index r*x_axis+c
//   clr_req      : one-cycle pulse to the array reg_clear after a capture
//   busy         : a captured tile has not been fully drained
//   out_valid    : out_data/out_row/out_last carry a row
//   out_ready    : downstream accepts the current row
//   out_data     : converted row, column c at [c*WIDTH_OUT +: WIDTH_OUT]
//   out_row      : row index of the current beat
//   out_last     : current beat is the final row of the tile
//   done         : one-cycle pulse after the final row is accepted
//   err_overrun  : sticky, start arrived while a tile was still draining

module sa_result_drain #(
    parameter int WIDTH_MAC = 48,
    parameter int WIDTH_OUT = 16,
    parameter int SIGNED    = 0,
    parameter int x_axis    = 3,
    parameter int y_axis    = 3,
    parameter int ROW_W     = (y_axis > 1) ? $clog2(y_axis) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [y_axis*x_axis*WIDTH_MAC-1:0] mac_flat,
    output logic                              clr_req,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [x_axis*WIDTH_OUT-1:0]       out_data,
    output logic [ROW_W-1:0]                  out_row,
    output logic                              out_last,
    output logic                              done,
    output logic                              err_overrun
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                              state, state_nxt;
    logic [ROW_W-1:0]                    row_p0, row_nxt;
    logic [y_axis*x_axis*WIDTH_MAC-1:0]  bank_p0;
    logic                                capture;
    logic                                done_nxt;
    logic                                overrun_set;
    logic                                accept;
    logic                                last_row;

    // Width reduction of one accumulator to one output element.
    function automatic logic [WIDTH_OUT-1:0] conv_elem(input logic [WIDTH_MAC-1:0] v);
`ifdef SA_DRAIN_SAT_EN
        logic signed [WIDTH_MAC-1:0] sv;
        logic signed [WIDTH_MAC-1:0] hi_s;
        logic        [WIDTH_MAC-1:0] hi_u;
        sv = $signed(v);
        if (SIGNED != 0) begin
            // In range exactly when every bit from the output sign bit upward
            // is a copy of the accumulator sign.
            hi_s = sv >>> (WIDTH_OUT - 1);
            if (hi_s == '0 || hi_s == '1) begin
                return v[WIDTH_OUT-1:0];
            end
            return sv[WIDTH_MAC-1] ? {1'b1, {(WIDTH_OUT-1){1'b0}}}
                                   : {1'b0, {(WIDTH_OUT-1){1'b1}}};
        end
        hi_u = v >> WIDTH_OUT;
        if (hi_u != '0) begin
            return '1;
        end
        return v[WIDTH_OUT-1:0];
`else
        // Truncation keeps the same low bits whatever the signedness.
        return (SIGNED != 0) ? v[WIDTH_OUT-1:0] : v[WIDTH_OUT-1:0];
`endif
    endfunction

    assign out_valid = (state == STREAM);
    assign busy      = out_valid;
    assign accept    = out_valid && out_ready;
    assign last_row  = (row_p0 == ROW_W'(y_axis - 1));
    assign out_last  = out_valid && last_row;
    assign out_row   = out_valid ? row_p0 : '0;

    always_comb begin
        state_nxt   = state;
        row_nxt     = row_p0;
        capture     = 1'b0;
        done_nxt    = 1'b0;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    row_nxt   = '0;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (accept && last_row) begin
                    done_nxt = 1'b1;
                    // A start on the final handshake chains straight into the
                    // next tile without an idle bubble.
                    if (start) begin
                        capture = 1'b1;
                        row_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    if (accept) begin
                        row_nxt = row_p0 + 1'b1;
                    end
                    if (start) begin
                        overrun_set = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage p0: control state and capture bank
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row_p0      <= '0;
            clr_req     <= 1'b0;
            done        <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            row_p0      <= row_nxt;
            clr_req     <= capture;
            done        <= done_nxt;
            err_overrun <= err_overrun | overrun_set;
        end
    end

    // The bank holds data only; the outputs are gated by out_valid, so a
    // reset does not need to clear it.
    always_ff @(posedge clk) begin
        if (capture) begin
            bank_p0 <= mac_flat;
        end
    end

    // Output stage: combinational conversion of the selected bank row
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int c = 0; c < x_axis; c++) begin
                out_data[c*WIDTH_OUT +: WIDTH_OUT] =
                    conv_elem(bank_p0[(int'(row_p0) * x_axis + c) * WIDTH_MAC +: WIDTH_MAC]);
            end
        end
    end

endmodule

// File: tb/tb_sa_result_drain.sv
module tb_sa_result_drain;

    localparam int WM = 48;
    localparam int WO = 16;
    localparam int X  = 3;
    localparam int Y  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // main instance: defaults (unsigned, 3x3)
    logic                  rst, start, out_ready;
    logic [Y*X*WM-1:0]     mac_flat;
    logic                  clr_req, busy, out_valid, out_last, done, err_overrun;
    logic [X*WO-1:0]       out_data;
    logic [1:0]            out_row;

    // second instance: signed, single row
    logic                  start2, out_ready2;
    logic [X*WM-1:0]       mac_flat2;
    logic                  clr_req2, busy2, out_valid2, out_last2, done2, err2;
    logic [X*WO-1:0]       out_data2;
    logic [0:0]            out_row2;

    logic [WM-1:0] m   [X*Y];   // matrix presented to the main instance
    logic [WM-1:0] snap[X*Y];   // model of the captured tile
    logic [WM-1:0] m2  [X];

    always_comb begin
        mac_flat = '0;
        for (int i = 0; i < X*Y; i++) mac_flat[i*WM +: WM] = m[i];
        mac_flat2 = '0;
        for (int i = 0; i < X; i++) mac_flat2[i*WM +: WM] = m2[i];
    end

    sa_result_drain #(.WIDTH_MAC(WM), .WIDTH_OUT(WO), .SIGNED(0), .x_axis(X), .y_axis(Y)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mac_flat(mac_flat), .clr_req(clr_req),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last), .done(done), .err_overrun(err_overrun));

    sa_result_drain #(.WIDTH_MAC(WM), .WIDTH_OUT(WO), .SIGNED(1), .x_axis(X), .y_axis(1)) u_sgn (
        .clk(clk), .rst(rst), .start(start2), .mac_flat(mac_flat2), .clr_req(clr_req2),
        .busy(busy2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_row(out_row2), .out_last(out_last2), .done(done2), .err_overrun(err2));

    // Reference conversion from the numeric value of the accumulator.
    function automatic logic [WO-1:0] ref_conv(input logic [WM-1:0] v, input bit sgn);
        longint val;
        if (sgn) val = longint'($signed(v));
        else     val = longint'(v);
`ifdef SA_DRAIN_SAT_EN
        if (sgn) begin
            if (val > 32767)  return 16'h7FFF;
            if (val < -32768) return 16'h8000;
        end else begin
            if (val > 65535)  return 16'hFFFF;
        end
`endif
        return val[WO-1:0];
    endfunction

    function automatic logic [X*WO-1:0] exp_row(input int r);
        logic [X*WO-1:0] e;
        for (int c = 0; c < X; c++) e[c*WO +: WO] = ref_conv(snap[r*X + c], 1'b0);
        return e;
    endfunction

    function automatic logic [WM-1:0] rand_val();
        longint t;
        case ($urandom_range(0, 3))
            0: t = longint'($urandom_range(0, 65535));
            1: t = {$urandom, $urandom};
            2: t = 65535 + longint'($urandom_range(0, 1));
            default: t = -longint'($urandom_range(1, 100000));
        endcase
        return t[WM-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic take_snap();
        for (int i = 0; i < X*Y; i++) snap[i] = m[i];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({clr_req, busy, out_valid, out_last, done, err_overrun} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=000000",
                     {clr_req, busy, out_valid, out_last, done, err_overrun});
        end
        checks++;
        if (out_data !== '0 || out_row !== '0) begin
            errors++;
            $display("FAIL reset_data got data=%h row=%0d exp 0/0", out_data, out_row);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        for (int r = 0; r < Y; r++)
            for (int c = 0; c < X; c++) m[r*X + c] = WM'(r*3 + c);
        out_ready = 1'b1;
        start = 1'b1;
        take_snap();
        step();
        start = 1'b0;
        for (int r = 0; r < Y; r++) begin
            checks++;
            if ({out_valid, clr_req, out_last} !== {1'b1, r == 0, r == Y-1}) begin
                errors++;
                $display("FAIL basic_ctl_row%0d got v/clr/last=%b exp=%b", r,
                         {out_valid, clr_req, out_last}, {1'b1, r == 0, r == Y-1});
            end
            checks++;
            if (out_data !== exp_row(r) || out_row !== 2'(r)) begin
                errors++;
                $display("FAIL basic_data_row%0d got %h/%0d exp %h/%0d", r, out_data, out_row,
                         exp_row(r), r);
            end
            step();
        end
        checks++;
        if ({done, busy, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL basic_done got done/busy/v=%b exp=100", {done, busy, out_valid});
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < X*Y; i++) m[i] = rand_val();
        out_ready = 1'b1;
        start = 1'b1;
        take_snap();
        step();
        start = 1'b0;
        for (int i = 0; i < X*Y; i++) m[i] = rand_val();   // array recomputes freely
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_row !== 2'd1 || out_data !== exp_row(1)) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b row=%0d data=%h exp v=1 row=1 data=%h",
                         k, out_valid, out_row, out_data, exp_row(1));
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_row !== 2'd2 || out_data !== exp_row(2) || out_last !== 1'b1) begin
            errors++;
            $display("FAIL stall_next got row=%0d data=%h last=%b exp row=2 data=%h last=1",
                     out_row, out_data, out_last, exp_row(2));
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_done got done=%b busy=%b exp 1/0", done, busy);
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < X*Y; i++) m[i] = rand_val();
        out_ready = 1'b1;
        start = 1'b1;
        take_snap();
        step();
        start = 1'b0;
        step();
        step();
        checks++;
        if (out_last !== 1'b1 || out_data !== exp_row(2)) begin
            errors++;
            $display("FAIL b2b_row2 got last=%b data=%h exp 1/%h", out_last, out_data, exp_row(2));
        end
        for (int i = 0; i < X*Y; i++) m[i] = WM'(7);
        start = 1'b1;
        take_snap();
        step();
        start = 1'b0;
        checks++;
        if (out_data !== {3{16'd7}} || out_row !== 2'd0) begin
            errors++;
            $display("FAIL b2b_new_row0 got %h/%0d exp %h/0", out_data, out_row, {3{16'd7}});
        end
        checks++;
        if ({clr_req, done, busy, err_overrun} !== 4'b1110) begin
            errors++;
            $display("FAIL b2b_ctl got clr/done/busy/err=%b exp=1110",
                     {clr_req, done, busy, err_overrun});
        end
        step();
        step();
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done got done=%b busy=%b exp 1/0", done, busy);
        end
        step();
    endtask

    task automatic test_overrun();
        for (int i = 0; i < X*Y; i++) m[i] = rand_val();
        out_ready = 1'b1;
        start = 1'b1;
        take_snap();
        step();
        for (int i = 0; i < X*Y; i++) m[i] = rand_val();
        start = 1'b1;                   // during row 0: must be ignored
        step();
        start = 1'b0;
        checks++;
        if (err_overrun !== 1'b1 || out_row !== 2'd1 || out_data !== exp_row(1)) begin
            errors++;
            $display("FAIL overrun_row1 got err=%b row=%0d data=%h exp 1/1/%h",
                     err_overrun, out_row, out_data, exp_row(1));
        end
        step();
        checks++;
        if (out_data !== exp_row(2)) begin
            errors++;
            $display("FAIL overrun_row2 got %h exp %h", out_data, exp_row(2));
        end
        step();
        step();
        checks++;
        if (err_overrun !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_sticky got err=%b busy=%b exp 1/0", err_overrun, busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear got=%b exp=0", err_overrun);
        end
    endtask

    task automatic test_conversion();
        longint t;
        logic [X*WO-1:0] e;
        m2[0] = WM'(40000);
        t = -40000;
        m2[1] = t[WM-1:0];
        m2[2] = WM'(123);
        out_ready2 = 1'b1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
`ifdef SA_DRAIN_SAT_EN
        e = {16'd123, 16'h8000, 16'h7FFF};
`else
        e = {16'h007B, 16'h63C0, 16'h9C40};
`endif
        checks++;
        if (out_data2 !== e) begin
            errors++;
            $display("FAIL conv_fixed got %h exp %h", out_data2, e);
        end
        checks++;
        if ({out_valid2, out_last2, out_row2, clr_req2} !== 4'b1101) begin
            errors++;
            $display("FAIL conv_single_row got v/last/row/clr=%b exp=1101",
                     {out_valid2, out_last2, out_row2, clr_req2});
        end
        step();
        checks++;
        if (done2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL conv_done got done=%b busy=%b exp 1/0", done2, busy2);
        end
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < X; c++) begin
                t = longint'($urandom_range(0, 262143)) - 131072;
                m2[c] = t[WM-1:0];
                e[c*WO +: WO] = ref_conv(m2[c], 1'b1);
            end
            start2 = 1'b1;
            step();
            start2 = 1'b0;
            checks++;
            if (out_data2 !== e) begin
                errors++;
                $display("FAIL conv_rand%0d got %h exp %h", k, out_data2, e);
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < X*Y; i++) m[i] = rand_val();
        out_ready = 1'b1;
        start = 1'b1;
        take_snap();
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({clr_req, busy, out_valid, out_last, done, err_overrun} !== 6'b0 ||
            out_data !== '0 || out_row !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got ctl=%b data=%h row=%0d exp all 0",
                     {clr_req, busy, out_valid, out_last, done, err_overrun}, out_data, out_row);
        end
        step();
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_done got done=%b v=%b exp 0/0", done, out_valid);
        end
        for (int i = 0; i < X*Y; i++) m[i] = rand_val();
        start = 1'b1;
        take_snap();
        step();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_row !== 2'd0 || out_data !== exp_row(0) || clr_req !== 1'b1) begin
            errors++;
            $display("FAIL midrst_restart got v=%b row=%0d data=%h clr=%b exp 1/0/%h/1",
                     out_valid, out_row, out_data, clr_req, exp_row(0));
        end
        step();
        step();
        step();
    endtask

    task automatic test_random();
        int exp_r;
        int budget;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < X*Y; i++) m[i] = rand_val();
            start = 1'b1;
            take_snap();
            step();
            start = 1'b0;
            for (int i = 0; i < X*Y; i++) m[i] = rand_val();
            exp_r = 0;
            budget = 0;
            while (exp_r < Y && budget < 200) begin
                out_ready = ($urandom_range(0, 2) != 0);
                checks++;
                if (out_valid !== 1'b1 || out_row !== 2'(exp_r) || out_data !== exp_row(exp_r) ||
                    out_last !== (exp_r == Y-1)) begin
                    errors++;
                    $display("FAIL rand%0d_row%0d got v=%b row=%0d data=%h last=%b exp data=%h",
                             t, exp_r, out_valid, out_row, out_data, out_last, exp_row(exp_r));
                end
                if (out_ready) exp_r++;
                step();
                budget++;
            end
            checks++;
            if (exp_r != Y) begin
                errors++;
                $display("FAIL rand%0d_timeout got rows=%0d exp=%0d", t, exp_r, Y);
            end
            checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_done got done=%b busy=%b exp 1/0", t, done, busy);
            end
            out_ready = 1'b1;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        out_ready = 1'b1;
        out_ready2 = 1'b1;
        for (int i = 0; i < X*Y; i++) m[i] = '0;
        for (int i = 0; i < X; i++) m2[i] = '0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_overrun();
        test_conversion();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
